// File: rtl/sub_run_pkg.sv
// Shared defaults and types for the run-length counter.
package sub_run_pkg;

    localparam int CNT_W_DEF        = 32;
    localparam int FINISH_COUNT_DEF = 3;
    localparam int ASSERT_LIMIT_DEF = 100;
    localparam int COVER_VALUE_DEF  = 3;

    typedef logic [CNT_W_DEF-1:0] run_cnt_t;

endpackage

// File: rtl/sub_run_counter.sv
// Run-length counter: counts edges after reset and freezes one past FINISH_COUNT.
// It also keeps sticky finished, assertion-error and coverage flags.
module sub_run_counter
    import sub_run_pkg::*;
#(
    parameter int CNT_W        = CNT_W_DEF,
    parameter int FINISH_COUNT = FINISH_COUNT_DEF,
    parameter int ASSERT_LIMIT = ASSERT_LIMIT_DEF,
    parameter int COVER_VALUE  = COVER_VALUE_DEF
) (
    input  logic             clk,
    input  logic             reset,
    output logic [CNT_W-1:0] count,
    output logic             finished,
    output logic             done_pulse,
    output logic             assert_err,
    output logic             cover_hit
);

    localparam logic [CNT_W-1:0] FINISH_C = CNT_W'(FINISH_COUNT);
    localparam logic [CNT_W-1:0] COVER_C  = CNT_W'(COVER_VALUE);
    // The limit may be 2^CNT_W (unreachable), so compare in a wider domain.
    localparam logic [63:0]      LIMIT_C  = 64'(ASSERT_LIMIT);

    logic [CNT_W-1:0] r_count;
    logic             r_finished;
    logic             r_done_pulse;
    logic             r_assert_err;
    logic             r_cover_hit;

    logic             w_fin_set;
    logic             w_aerr_set;
    logic             w_cov_set;

    // Flag set conditions, all evaluated on the pre-edge count.
    always_comb begin
        w_fin_set  = 1'b0;
        w_aerr_set = 1'b0;
        w_cov_set  = 1'b0;
        if (!r_finished && (r_count >= FINISH_C)) begin
            w_fin_set = 1'b1;
        end else begin
            w_fin_set = 1'b0;
        end
        if (64'(r_count) >= LIMIT_C) begin
            w_aerr_set = 1'b1;
        end else begin
            w_aerr_set = 1'b0;
        end
        if (r_count == COVER_C) begin
            w_cov_set = 1'b1;
        end else begin
            w_cov_set = 1'b0;
        end
    end

    // Counter and sticky flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count      <= '0;
            r_finished   <= 1'b0;
            r_done_pulse <= 1'b0;
            r_assert_err <= 1'b0;
            r_cover_hit  <= 1'b0;
        end else begin
            if (!r_finished) begin
                r_count <= r_count + CNT_W'(1);
            end else begin
                r_count <= r_count;
            end
            r_finished   <= r_finished | w_fin_set;
            r_done_pulse <= w_fin_set;
            r_assert_err <= r_assert_err | w_aerr_set;
            r_cover_hit  <= r_cover_hit | w_cov_set;
        end
    end

    assign count      = r_count;
    assign finished   = r_finished;
    assign done_pulse = r_done_pulse;
    assign assert_err = r_assert_err;
    assign cover_hit  = r_cover_hit;

endmodule

// File: tb/tb_sub_run_counter.sv
// Scoreboard bench for sub_run_counter: three parameterisations driven by a
// shared clock and reset, checked against a closed-form edge-count model.
module tb_sub_run_counter;

    typedef struct {
        int cnt;
        bit fin;
        bit done;
        bit aerr;
        bit cov;
    } exp_t;

    typedef struct {
        exp_t d;
        exp_t a;
        exp_t w;
    } exp_set_t;

    logic        clk;
    logic        reset;

    logic [31:0] d_count;
    logic        d_fin, d_done, d_aerr, d_cov;
    logic [31:0] a_count;
    logic        a_fin, a_done, a_aerr, a_cov;
    logic [3:0]  w_count;
    logic        w_fin, w_done, w_aerr, w_cov;

    int n_checks;
    int n_fail;
    exp_set_t sb[$];

    sub_run_counter u_def (
        .clk(clk), .reset(reset), .count(d_count), .finished(d_fin),
        .done_pulse(d_done), .assert_err(d_aerr), .cover_hit(d_cov)
    );

    sub_run_counter #(.CNT_W(32), .FINISH_COUNT(10), .ASSERT_LIMIT(5), .COVER_VALUE(3)) u_assert (
        .clk(clk), .reset(reset), .count(a_count), .finished(a_fin),
        .done_pulse(a_done), .assert_err(a_aerr), .cover_hit(a_cov)
    );

    sub_run_counter #(.CNT_W(4), .FINISH_COUNT(14), .ASSERT_LIMIT(16), .COVER_VALUE(3)) u_wrap (
        .clk(clk), .reset(reset), .count(w_count), .finished(w_fin),
        .done_pulse(w_done), .assert_err(w_aerr), .cover_hit(w_cov)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Expected outputs k edges after reset release (k = 0 while in reset).
    function automatic exp_t model(input int k, input int fin, input int lim, input int cov);
        exp_t e;
        e.cnt  = (k < fin + 1) ? k : fin + 1;
        e.fin  = (k >= fin + 1);
        e.done = (k == fin + 1);
        e.aerr = (lim <= fin + 1) && (k >= lim + 1);
        e.cov  = (cov <= fin + 1) && (k >= cov + 1);
        return e;
    endfunction

    task automatic push_exp(input int k);
        exp_set_t s;
        s.d = model(k, 3, 100, 3);
        s.a = model(k, 10, 5, 3);
        s.w = model(k, 14, 16, 3);
        sb.push_back(s);
    endtask

    task automatic sample(input int k);
        exp_set_t s;
        string sfx;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_empty: got no entry, expected one at k=%0d", k);
        end else begin
            s = sb.pop_front();
            sfx = $sformatf("@k%0d", k);
            check({"def_cnt", sfx},   d_count,       32'(s.d.cnt));
            check({"def_fin", sfx},   32'(d_fin),    32'(s.d.fin));
            check({"def_done", sfx},  32'(d_done),   32'(s.d.done));
            check({"def_aerr", sfx},  32'(d_aerr),   32'(s.d.aerr));
            check({"def_cov", sfx},   32'(d_cov),    32'(s.d.cov));
            check({"asrt_cnt", sfx},  a_count,       32'(s.a.cnt));
            check({"asrt_fin", sfx},  32'(a_fin),    32'(s.a.fin));
            check({"asrt_done", sfx}, 32'(a_done),   32'(s.a.done));
            check({"asrt_aerr", sfx}, 32'(a_aerr),   32'(s.a.aerr));
            check({"asrt_cov", sfx},  32'(a_cov),    32'(s.a.cov));
            check({"wrap_cnt", sfx},  32'(w_count),  32'(s.w.cnt));
            check({"wrap_fin", sfx},  32'(w_fin),    32'(s.w.fin));
            check({"wrap_done", sfx}, 32'(w_done),   32'(s.w.done));
            check({"wrap_aerr", sfx}, 32'(w_aerr),   32'(s.w.aerr));
            check({"wrap_cov", sfx},  32'(w_cov),    32'(s.w.cov));
        end
    endtask

    task automatic tick(input int k);
        push_exp(k);
        @(posedge clk);
        #1;
        sample(k);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;

        // Reset held with clock running.
        for (int i = 0; i < 5; i++) tick(0);
        reset = 1'b0;

        for (int k = 1; k <= 2; k++) tick(k);

        // Asynchronous reset between edges at count = 2.
        #3;
        reset = 1'b1;
        #1;
        push_exp(0);
        sample(0);
        for (int i = 0; i < 2; i++) tick(0);
        reset = 1'b0;

        // Full run: default finishes at edge 4, assert variant errors at 6 and
        // finishes at 11, 4-bit variant freezes at 15 without wrapping.
        for (int k = 1; k <= 20; k++) tick(k);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
